tag_match_encoder_pipe: RTL

//  Parametrised, pipelined successor to the 32-way sampler tag-match encoder.

---
 rtl/tag_match_encoder_pipe_if.sv | 31 +++
 rtl/tag_match_encoder_pipe.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/tag_match_encoder_pipe_if.sv
// Handshake and result bundle between the sampler tag comparators, the
// tag-match encoder and the reuse-interval update logic.
interface tag_match_encoder_pipe_if #(
  parameter int N_WAYS = 32,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = $clog2(N_WAYS)
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [N_WAYS-1:0] match_bits_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [IDX_W-1:0]  match_index_o;
  logic              match_hit_o;
  logic              multi_hit_o;
  logic              stats_clear_i;
  logic [CNT_W-1:0]  hit_count_o;
  logic [CNT_W-1:0]  multi_count_o;

  modport master (
    output in_valid_i, match_bits_i, out_ready_i, stats_clear_i,
    input  in_ready_o, out_valid_o, match_index_o, match_hit_o, multi_hit_o,
           hit_count_o, multi_count_o
  );

  modport slave (
    input  in_valid_i, match_bits_i, out_ready_i, stats_clear_i,
    output in_ready_o, out_valid_o, match_index_o, match_hit_o, multi_hit_o,
           hit_count_o, multi_count_o
  );
endinterface

// File: rtl/tag_match_encoder_pipe.sv
// Two-stage tag-match encoder: per-group reduction, then a group merge into a
// binary way index with hit/multi-hit flags and saturating statistics counters.
module tag_match_encoder_pipe #(
  parameter int N_WAYS        = 32,
  parameter int GROUP_W       = 8,
  parameter int IDX_W         = $clog2(N_WAYS),
  parameter int PRIORITY_MODE = 1,
  parameter int CNT_W         = 16
) (
  input logic                     clock_i,
  input logic                     reset_i,
  tag_match_encoder_pipe_if.slave bus
);
  localparam int N_GROUPS = N_WAYS / GROUP_W;
  localparam int LIDX_W   = (GROUP_W > 1) ? $clog2(GROUP_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if ((N_WAYS % GROUP_W) != 0) begin : g_bad_group_split
    $error("N_WAYS must be a multiple of GROUP_W");
  end
  if ((GROUP_W & (GROUP_W - 1)) != 0) begin : g_bad_group_width
    $error("GROUP_W must be a power of two");
  end
  if (IDX_W != $clog2(N_WAYS)) begin : g_bad_idx_width
    $error("IDX_W is derived from N_WAYS and must not be overridden");
  end

  function automatic logic [LIDX_W-1:0] lowest_idx(input logic [GROUP_W-1:0] bits);
    logic [LIDX_W-1:0] idx;
    idx = '0;
    for (int i = GROUP_W - 1; i >= 0; i--) begin
      if (bits[i]) idx = LIDX_W'(i);
      else         idx = idx;
    end
    return idx;
  endfunction

  function automatic logic [LIDX_W-1:0] or_idx(input logic [GROUP_W-1:0] bits);
    logic [LIDX_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < GROUP_W; i++) begin
      if (bits[i]) acc = acc | LIDX_W'(i);
      else         acc = acc;
    end
    return acc;
  endfunction

  // x & (x-1) is non-zero exactly when two or more bits are set
  function automatic logic multi_set(input logic [GROUP_W-1:0] bits);
    return |(bits & (bits - GROUP_W'(1'b1)));
  endfunction

  logic                             adv_s;
  logic                             accept_s;
  logic [N_GROUPS-1:0]              g_hit_s;
  logic [N_GROUPS-1:0]              g_multi_s;
  logic [N_GROUPS-1:0][LIDX_W-1:0]  g_idx_s;
  logic                             s1_valid_r;
  logic [N_GROUPS-1:0]              s1_hit_r;
  logic [N_GROUPS-1:0]              s1_multi_r;
  logic [N_GROUPS-1:0][LIDX_W-1:0]  s1_idx_r;
  logic                             hit_s;
  logic                             multi_s;
  logic [IDX_W-1:0]                 index_s;
  logic                             out_valid_r;
  logic [IDX_W-1:0]                 index_r;
  logic                             hit_r;
  logic                             multi_r;
  logic [CNT_W-1:0]                 hit_cnt_r;
  logic [CNT_W-1:0]                 multi_cnt_r;

  assign adv_s    = !out_valid_r | bus.out_ready_i;
  assign accept_s = out_valid_r & bus.out_ready_i;

  // Stage-1 per-group reduction of the raw match vector
  always_comb begin
    g_hit_s   = '0;
    g_multi_s = '0;
    g_idx_s   = '0;
    for (int g = 0; g < N_GROUPS; g++) begin
      g_hit_s[g]   = |bus.match_bits_i[g*GROUP_W +: GROUP_W];
      g_multi_s[g] = multi_set(bus.match_bits_i[g*GROUP_W +: GROUP_W]);
      if (PRIORITY_MODE == 1) g_idx_s[g] = lowest_idx(bus.match_bits_i[g*GROUP_W +: GROUP_W]);
      else                    g_idx_s[g] = or_idx(bus.match_bits_i[g*GROUP_W +: GROUP_W]);
    end
  end

  // Stage-1 registers, frozen while the output is stalled
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      s1_valid_r <= 1'b0;
      s1_hit_r   <= '0;
      s1_multi_r <= '0;
      s1_idx_r   <= '0;
    end else if (adv_s) begin
      s1_valid_r <= bus.in_valid_i;
      if (bus.in_valid_i) begin
        s1_hit_r   <= g_hit_s;
        s1_multi_r <= g_multi_s;
        s1_idx_r   <= g_idx_s;
      end
    end
  end

  // Stage-2 group merge into the final index and flags
  always_comb begin
    hit_s   = |s1_hit_r;
    multi_s = (|s1_multi_r) | (|(s1_hit_r & (s1_hit_r - N_GROUPS'(1'b1))));
    index_s = '0;
    if (PRIORITY_MODE == 1) begin
      for (int g = N_GROUPS - 1; g >= 0; g--) begin
        if (s1_hit_r[g]) index_s = IDX_W'(g * GROUP_W) + IDX_W'(s1_idx_r[g]);
        else             index_s = index_s;
      end
    end else begin
      for (int g = 0; g < N_GROUPS; g++) begin
        if (s1_hit_r[g]) index_s = index_s | IDX_W'(g * GROUP_W) | IDX_W'(s1_idx_r[g]);
        else             index_s = index_s;
      end
    end
  end

  // Output registers; data fields hold through bubbles
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      out_valid_r <= 1'b0;
      index_r     <= '0;
      hit_r       <= 1'b0;
      multi_r     <= 1'b0;
    end else if (adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        index_r <= index_s;
        hit_r   <= hit_s;
        multi_r <= multi_s;
      end
    end
  end

  // Saturating statistics; a clear wins over a same-cycle accept
  always_ff @(posedge clock_i) begin
    if (reset_i || bus.stats_clear_i) begin
      hit_cnt_r   <= '0;
      multi_cnt_r <= '0;
    end else if (accept_s) begin
      if (hit_r && (hit_cnt_r != CNT_MAX))     hit_cnt_r   <= hit_cnt_r + CNT_W'(1'b1);
      if (multi_r && (multi_cnt_r != CNT_MAX)) multi_cnt_r <= multi_cnt_r + CNT_W'(1'b1);
    end
  end

  assign bus.in_ready_o    = adv_s;
  assign bus.out_valid_o   = out_valid_r;
  assign bus.match_index_o = index_r;
  assign bus.match_hit_o   = hit_r;
  assign bus.multi_hit_o   = multi_r;
  assign bus.hit_count_o   = hit_cnt_r;
  assign bus.multi_count_o = multi_cnt_r;
endmodule
